// File: rtl/parser_arb_pkg.sv
// Shared definitions for the parser input arbiter: FSM state encodings,
// a constant-function clog2 and the round-robin wrap increment.
package parser_arb_pkg;

    // Two-state arbiter FSM encoding (legacy-compatible constants)
    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_SEND = 1'b1;

    // Ceiling log2, usable in parameter expressions
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Next port index after id, wrapping limit-1 back to 0
    function automatic int wrap_inc(input int id, input int limit);
        return (id + 1 >= limit) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin priority encoder: picks the first asserted request found by
// searching upward from rr_ptr with wrap-around. Purely combinational.
module rr_priority_encoder
    import parser_arb_pkg::*;
#(
    parameter int NUM_PORTS     = 4,
    parameter int PORT_ID_WIDTH = 2
) (
    input  logic [NUM_PORTS-1:0]     req,
    input  logic [PORT_ID_WIDTH-1:0] rr_ptr,
    output logic [PORT_ID_WIDTH-1:0] winner,
    output logic                     any_req
);

    logic [PORT_ID_WIDTH-1:0] idx;

    // Walk the ports in rr_ptr order; the first requester wins. Only indices
    // below NUM_PORTS are ever visited, so an out-of-range id cannot win.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = PORT_ID_WIDTH'((int'(rr_ptr) + k) % NUM_PORTS);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

endmodule

// File: rtl/parser_input_arbiter.sv
// Packet-level round-robin arbiter sharing one packet_header_parser between
// NUM_PORTS AXI-Stream ingress ports. A grant is held until the granted
// port's tlast beat completes, so packets are never interleaved. The granted
// port's beat passes to the parser combinationally and tready passes back.
// Optional build macro PARSER_ARB_PKT_CNT_EN adds per-port 32-bit completed
// packet counters on output pkt_cnt.
module parser_input_arbiter
    import parser_arb_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS            = 4,
    parameter int PORT_ID_WIDTH        = 2
) (
    input  logic                                      axis_clk,
    input  logic                                      aresetn,
    input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                      s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                      s_axis_tlast,
    output logic [NUM_PORTS-1:0]                      s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]          m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]           m_axis_tuser,
    output logic                                      m_axis_tvalid,
    output logic                                      m_axis_tlast,
    input  logic                                      m_axis_tready,
    output logic [PORT_ID_WIDTH-1:0]                  grant_id,
    output logic                                      busy
`ifdef PARSER_ARB_PKT_CNT_EN
    ,
    output logic [NUM_PORTS*32-1:0]                   pkt_cnt
`endif
);

    localparam int DW      = C_S_AXIS_DATA_WIDTH;
    localparam int KW      = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW      = C_S_AXIS_TUSER_WIDTH;
    localparam int MIN_IDW = (clog2(NUM_PORTS) < 1) ? 1 : clog2(NUM_PORTS);

    // Reject an id width too narrow to name every port
    if (PORT_ID_WIDTH < MIN_IDW) begin : g_bad_id_width
        $error("PORT_ID_WIDTH too small for NUM_PORTS");
    end

    logic [0:0]               state;
    logic [PORT_ID_WIDTH-1:0] rr_ptr;
    logic [PORT_ID_WIDTH-1:0] winner;
    logic                     any_req;
    logic                     beat_done;

    // Per-port views of the flattened ingress buses
    logic [DW-1:0] tdata_arr [NUM_PORTS];
    logic [KW-1:0] tkeep_arr [NUM_PORTS];
    logic [UW-1:0] tuser_arr [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slice
        assign tdata_arr[i] = s_axis_tdata[i*DW +: DW];
        assign tkeep_arr[i] = s_axis_tkeep[i*KW +: KW];
        assign tuser_arr[i] = s_axis_tuser[i*UW +: UW];
    end

    rr_priority_encoder #(
        .NUM_PORTS     (NUM_PORTS),
        .PORT_ID_WIDTH (PORT_ID_WIDTH)
    ) u_rr_enc (
        .req     (s_axis_tvalid),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // Pass the granted port straight through while sending; quiet bus in IDLE
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        busy          = 1'b0;
        if (state == ARB_SEND) begin
            m_axis_tdata            = tdata_arr[grant_id];
            m_axis_tkeep            = tkeep_arr[grant_id];
            m_axis_tuser            = tuser_arr[grant_id];
            m_axis_tvalid           = s_axis_tvalid[grant_id];
            m_axis_tlast            = s_axis_tlast[grant_id];
            s_axis_tready[grant_id] = m_axis_tready;
            busy                    = 1'b1;
        end
    end

    // A packet ends on the handshake of its tlast beat
    assign beat_done = (state == ARB_SEND) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Grant FSM: latch the winner in IDLE, hold it until the packet completes,
    // then advance the round-robin pointer past the port just served
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= ARB_IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        grant_id <= winner;
                        state    <= ARB_SEND;
                    end
                end
                ARB_SEND: begin
                    if (beat_done) begin
                        state  <= ARB_IDLE;
                        rr_ptr <= PORT_ID_WIDTH'(wrap_inc(int'(grant_id), NUM_PORTS));
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef PARSER_ARB_PKT_CNT_EN
    logic [31:0] cnt_r [NUM_PORTS];

    // Count completed packets per granted port; wraps naturally at 2^32
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_r[i] <= '0;
            end
        end else if (beat_done) begin
            cnt_r[grant_id] <= cnt_r[grant_id] + 32'd1;
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt_out
        assign pkt_cnt[i*32 +: 32] = cnt_r[i];
    end
`endif

endmodule

// File: tb/tb_parser_input_arbiter.sv
// Self-checking bench for parser_input_arbiter: directed scenarios plus a
// randomized phase, compared against a packet-level reference model.
module tb_parser_input_arbiter;

    localparam int DW = 64;
    localparam int UW = 16;
    localparam int KW = DW / 8;
    localparam int NP = 4;
    localparam int PW = 2;

    logic              axis_clk = 1'b0;
    logic              aresetn;
    logic [NP*DW-1:0]  s_axis_tdata;
    logic [NP*KW-1:0]  s_axis_tkeep;
    logic [NP*UW-1:0]  s_axis_tuser;
    logic [NP-1:0]     s_axis_tvalid;
    logic [NP-1:0]     s_axis_tlast;
    logic [NP-1:0]     s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic [UW-1:0]     m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic [PW-1:0]     grant_id;
    logic              busy;
`ifdef PARSER_ARB_PKT_CNT_EN
    logic [NP*32-1:0]  pkt_cnt;
`endif

    always #5 axis_clk = ~axis_clk;

    parser_input_arbiter #(
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .NUM_PORTS            (NP),
        .PORT_ID_WIDTH        (PW)
    ) dut (
        .axis_clk      (axis_clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .grant_id      (grant_id),
        .busy          (busy)
`ifdef PARSER_ARB_PKT_CNT_EN
        ,
        .pkt_cnt       (pkt_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Upstream sources: queue of packet lengths per port plus current beat
    int            len_q [NP][$];
    int            beat_idx [NP];
    logic [DW-1:0] cur_data [NP];
    logic [KW-1:0] cur_keep [NP];
    logic [UW-1:0] cur_user [NP];
    logic [NP-1:0] vld;
    bit            hs [NP];
    bit            gap_en;
    bit            rand_ready;

    // Reference model: packet-level grant state
    bit m_busy;
    int m_gid;
    int m_ptr;
    int m_cnt [NP];

    // Observations of the DUT for scenario-level checks
    int dut_log [$];
    int dut_busy_cycles;
    bit prev_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void new_beat(input int p);
        cur_data[p] = {$urandom, $urandom};
        cur_keep[p] = KW'($urandom);
        cur_user[p] = UW'($urandom);
    endfunction

    function automatic bit is_last(input int p);
        return (len_q[p].size() > 0) && (beat_idx[p] == len_q[p][0] - 1);
    endfunction

    function automatic bit any_pending();
        bit r = 1'b0;
        for (int p = 0; p < NP; p++) if (len_q[p].size() > 0) r = 1'b1;
        return r;
    endfunction

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            s_axis_tdata[p*DW +: DW] = cur_data[p];
            s_axis_tkeep[p*KW +: KW] = cur_keep[p];
            s_axis_tuser[p*UW +: UW] = cur_user[p];
            s_axis_tvalid[p]         = vld[p];
            s_axis_tlast[p]          = is_last(p);
        end
    endtask

    // A beat offered but not yet accepted stays put; otherwise maybe offer next
    function automatic void refresh_valid();
        for (int p = 0; p < NP; p++) begin
            if (!(vld[p] && !hs[p]))
                vld[p] = (len_q[p].size() > 0) && (!gap_en || ($urandom_range(0, 3) != 0));
        end
    endfunction

    task automatic load(input int p, input int len);
        if (len_q[p].size() == 0) begin
            beat_idx[p] = 0;
            new_beat(p);
        end
        len_q[p].push_back(len);
        hs[p] = 1'b0;
        refresh_valid();
        drive();
    endtask

    task automatic check_outputs();
        logic [NP-1:0] exp_rdy;
        exp_rdy = '0;
        if (m_busy) begin
            exp_rdy[m_gid] = m_axis_tready;
            chk("m_tdata", 64'(m_axis_tdata), 64'(cur_data[m_gid]));
            chk("m_tkeep", 64'(m_axis_tkeep), 64'(cur_keep[m_gid]));
            chk("m_tuser", 64'(m_axis_tuser), 64'(cur_user[m_gid]));
            chk("m_tvalid", 64'(m_axis_tvalid), 64'(vld[m_gid]));
            chk("m_tlast", 64'(m_axis_tlast), 64'(is_last(m_gid)));
        end else begin
            chk("idle_tdata", 64'(m_axis_tdata), 64'd0);
            chk("idle_tkeep", 64'(m_axis_tkeep), 64'd0);
            chk("idle_tuser", 64'(m_axis_tuser), 64'd0);
            chk("idle_tvalid", 64'(m_axis_tvalid), 64'd0);
            chk("idle_tlast", 64'(m_axis_tlast), 64'd0);
        end
        chk("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("grant_id", 64'(grant_id), 64'(m_gid));
`ifdef PARSER_ARB_PKT_CNT_EN
        for (int p = 0; p < NP; p++)
            chk("pkt_cnt", 64'(pkt_cnt[p*32 +: 32]), 64'(32'(m_cnt[p])));
`endif
    endtask

    // One clock: check at negedge, advance model and sources after posedge
    task automatic step();
        bool_blk: begin
            bit found;
            @(negedge axis_clk);
            check_outputs();
            if (busy && !prev_busy) dut_log.push_back(int'(grant_id));
            prev_busy = busy;
            if (busy) dut_busy_cycles++;
            for (int p = 0; p < NP; p++)
                hs[p] = m_busy && (p == m_gid) && vld[p] && m_axis_tready;
            if (m_busy) begin
                if (hs[m_gid] && is_last(m_gid)) begin
                    m_busy = 1'b0;
                    m_cnt[m_gid]++;
                    m_ptr = (m_gid + 1) % NP;
                end
            end else begin
                found = 1'b0;
                for (int k = 0; k < NP; k++) begin
                    int q;
                    q = (m_ptr + k) % NP;
                    if (!found && vld[q]) begin
                        found  = 1'b1;
                        m_busy = 1'b1;
                        m_gid  = q;
                    end
                end
            end
            @(posedge axis_clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (hs[p]) begin
                    beat_idx[p]++;
                    if (beat_idx[p] == len_q[p][0]) begin
                        void'(len_q[p].pop_front());
                        beat_idx[p] = 0;
                    end
                    new_beat(p);
                end
            end
            refresh_valid();
            if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
            drive();
        end
    endtask

    task automatic drain(input int budget, output int cycles);
        cycles = 0;
        while ((any_pending() || m_busy) && cycles < budget) begin
            step();
            cycles++;
        end
        chk("drain_within_budget", 64'(cycles < budget), 64'd1);
        step();
    endtask

    task automatic clear_state();
        m_busy = 1'b0;
        m_gid  = 0;
        m_ptr  = 0;
        for (int p = 0; p < NP; p++) begin
            len_q[p].delete();
            beat_idx[p] = 0;
            m_cnt[p]    = 0;
            hs[p]       = 1'b0;
            new_beat(p);
        end
        vld       = '0;
        prev_busy = 1'b0;
        drive();
    endtask

    task automatic check_reset_outputs();
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
`ifdef PARSER_ARB_PKT_CNT_EN
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
    endtask

    // Called just after a posedge; asserts reset mid-cycle and returns likewise
    task automatic do_reset();
        #2 aresetn = 1'b0;
        #1 check_reset_outputs();
        clear_state();
        @(posedge axis_clk);
        @(posedge axis_clk);
        #3 aresetn = 1'b1;
        @(posedge axis_clk);
        #1;
    endtask

    task automatic clear_logs();
        dut_log.delete();
        dut_busy_cycles = 0;
    endtask

    initial begin
        int cyc;
        int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int pat [4] = '{1, 0, 0, 1};

        aresetn       = 1'b0;
        m_axis_tready = 1'b1;
        gap_en        = 1'b0;
        rand_ready    = 1'b0;
        clear_state();
        @(posedge axis_clk);
        @(posedge axis_clk);
        #1 check_reset_outputs();
        #2 aresetn = 1'b1;
        @(posedge axis_clk);
        #1;

        // Port 2, 3-beat packet at full rate
        clear_logs();
        load(2, 3);
        drain(50, cyc);
        chk("t1_grants", 64'(dut_log.size()), 64'd1);
        chk("t1_grant0", 64'(dut_log[0]), 64'd2);
        chk("t1_busy_cycles", 64'(dut_busy_cycles), 64'd3);
        chk("t1_cycles", 64'(cyc), 64'd4);

        // All ports with two 2-beat packets each, starting from pointer 0
        do_reset();
        clear_logs();
        for (int p = 0; p < NP; p++) begin
            load(p, 2);
            load(p, 2);
        end
        drain(200, cyc);
        chk("t2_grants", 64'(dut_log.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            chk("t2_order", 64'(dut_log[i]), 64'(exp_order[i]));
        chk("t2_busy_cycles", 64'(dut_busy_cycles), 64'd16);
        chk("t2_cycles_one_bubble", 64'(cyc), 64'd24);

        // Port 1 stalled by parser backpressure while port 3 also waits
        clear_logs();
        load(1, 4);
        load(3, 2);
        step();
        for (int i = 0; i < 4; i++) begin
            m_axis_tready = 1'(pat[i]);
            drive();
            step();
        end
        m_axis_tready = 1'b1;
        drive();
        drain(100, cyc);
        chk("t3_grants", 64'(dut_log.size()), 64'd2);
        chk("t3_grant0", 64'(dut_log[0]), 64'd1);
        chk("t3_grant1", 64'(dut_log[1]), 64'd3);

        // Back-to-back single-beat packets on ports 0 and 3
        do_reset();
        clear_logs();
        load(0, 1);
        load(3, 1);
        drain(50, cyc);
        chk("t4_grants", 64'(dut_log.size()), 64'd2);
        chk("t4_grant0", 64'(dut_log[0]), 64'd0);
        chk("t4_grant1", 64'(dut_log[1]), 64'd3);
        chk("t4_busy_cycles", 64'(dut_busy_cycles), 64'd2);

        // Reset in the middle of a 4-beat packet on port 1 (pointer was 2)
        load(1, 1);
        drain(50, cyc);
        load(1, 4);
        step();
        step();
        step();
        chk("t5_pre_busy", 64'(busy), 64'd1);
        do_reset();
        clear_logs();
        load(3, 1);
        load(1, 1);
        drain(50, cyc);
        chk("t5_grant0", 64'(dut_log[0]), 64'd1);
        chk("t5_grant1", 64'(dut_log[1]), 64'd3);

        // Randomized traffic with source gaps and parser backpressure
        clear_logs();
        gap_en     = 1'b1;
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++)
            load(int'($urandom_range(0, NP - 1)), int'($urandom_range(1, 6)));
        drain(4000, cyc);
        chk("t6_packets", 64'(dut_log.size()), 64'd40);
        gap_en        = 1'b0;
        rand_ready    = 1'b0;
        m_axis_tready = 1'b1;
        drive();

`ifdef PARSER_ARB_PKT_CNT_EN
        // Per-port packet counters: 5 packets on port 0, 2 on port 3
        do_reset();
        for (int i = 0; i < 5; i++) load(0, int'($urandom_range(1, 4)));
        for (int i = 0; i < 2; i++) load(3, int'($urandom_range(1, 4)));
        drain(200, cyc);
        chk("t7_cnt0", 64'(pkt_cnt[0 +: 32]), 64'd5);
        chk("t7_cnt1", 64'(pkt_cnt[32 +: 32]), 64'd0);
        chk("t7_cnt2", 64'(pkt_cnt[64 +: 32]), 64'd0);
        chk("t7_cnt3", 64'(pkt_cnt[96 +: 32]), 64'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parser_input_arbiter.md
Name: parser_input_arbiter

Overview:
- Packet-level round-robin arbiter that shares one packet_header_parser between NUM_PORTS AXI-Stream ingress ports.
- Sits in front of the parser inside the processing top level.
- Grants one port at a time and holds the grant until that port's tlast beat completes, so packets are never interleaved.
- Granted port's data and control pass through to the parser combinationally; backpressure passes straight back.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, tdata width per port; tkeep width is this /8.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width per port.
- NUM_PORTS, 4, number of ingress ports; legal range 2..8.
- PORT_ID_WIDTH, 2, clog2(NUM_PORTS); legal range 1..3.

Ports:
- axis_clk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  NUM_PORTS*C_S_AXIS_DATA_WIDTH  flattened ingress data; port i occupies slice i.
- s_axis_tkeep  in  NUM_PORTS*C_S_AXIS_DATA_WIDTH/8  flattened ingress keep.
- s_axis_tuser  in  NUM_PORTS*C_S_AXIS_TUSER_WIDTH  flattened ingress user.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port last.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- m_axis_tdata  out  C_S_AXIS_DATA_WIDTH  to parser.
- m_axis_tkeep  out  C_S_AXIS_DATA_WIDTH/8  to parser.
- m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH  to parser.
- m_axis_tvalid  out  1  to parser.
- m_axis_tlast  out  1  to parser.
- m_axis_tready  in  1  from parser.
- grant_id  out  PORT_ID_WIDTH  currently granted port.
- busy  out  1  high while a packet is in flight.

Behaviour:
- Clock and reset: one clock, axis_clk; asynchronous active-low reset, aresetn.
- Reset values:
  - state=IDLE, grant_id=0, rr_ptr=0, busy=0.
  - s_axis_tready all 0, m_axis_tvalid=0.
  - m_axis_tdata/tkeep/tuser/tlast driven 0 while IDLE.
- FSM, two states:
  - IDLE:
    - All s_axis_tready=0, m_axis_tvalid=0.
    - If any s_axis_tvalid is high, choose the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NUM_PORTS-1, 0, ...).
    - Register the winner into grant_id and go to SEND next cycle.
    - No request: stay in IDLE.
  - SEND:
    - m_axis_* = slice grant_id of s_axis_*, combinational.
    - s_axis_tready[grant_id] = m_axis_tready; all other tready bits = 0.
    - busy=1.
    - On a beat with m_axis_tvalid & m_axis_tready & m_axis_tlast: go to IDLE and set rr_ptr = grant_id+1, wrapping NUM_PORTS-1 to 0.
- Latency and throughput:
  - 1 cycle from first tvalid in IDLE to the first beat presented; 0-cycle pass-through afterwards.
  - Exactly one idle bubble between consecutive packets; full rate within a packet.
- Boundary conditions:
  - Simultaneous requests are resolved strictly by rr_ptr order, giving no starvation. Each port waits at most NUM_PORTS-1 packets.
  - A single-beat packet (tvalid & tlast on the first beat) takes SEND for one handshake, then returns to IDLE.
  - Granted port drops tvalid mid-packet: stay in SEND, m_axis_tvalid follows it low, grant held.
  - m_axis_tready low: hold. The upstream port must keep its beat stable.
  - A request appearing in the same cycle that SEND exits is evaluated in the following IDLE cycle.
  - Reset mid-packet: immediate return to IDLE with rr_ptr=0. Recovering from the truncated packet is the upstream's responsibility.
  - A port ID >= NUM_PORTS is never granted.

Optional Feature:
- Macro: PARSER_ARB_PKT_CNT_EN.
- Defined:
  - Adds output pkt_cnt [NUM_PORTS*32-1:0], one 32-bit counter per port.
  - A port's counter increments on each completed tlast handshake of a packet granted to that port.
  - Counters wrap 0xFFFFFFFF->0; reset value 0.
- Undefined: port and counters are absent; no other change.

Decomposition:
- Shared package parser_arb_pkg holds:
  - Constant ARB_IDLE/ARB_SEND encodings.
  - Function clog2.
  - Function for the wrap increment.
- Sub-module: rr_priority_encoder (NUM_PORTS, PORT_ID_WIDTH).
  - Inputs: req vector, rr_ptr.
  - Outputs: winner id, any_req.
  - Purely combinational; reused elsewhere in the pipeline.

Test Plan:
- Reset, then port 2 sends a 3-beat packet with m_axis_tready=1 -> first beat appears 1 cycle after tvalid; grant_id=2; busy high for 3 cycles; rr_ptr=3 afterwards.
- All 4 ports hold 2-beat packets continuously from rr_ptr=0 -> grant order 0,1,2,3,0; one bubble between packets; no interleaving.
- Port 1 mid-packet with m_axis_tready toggling 1,0,0,1 -> beats stall; s_axis_tready[1] mirrors m_axis_tready; other tready bits stay 0.
- Back-to-back single-beat packets on ports 0 and 3 -> grants 0 then 3, each busy for 1 cycle.
- aresetn asserted during beat 2 of a 4-beat packet on port 1 -> all outputs 0 asynchronously; next grant searches from port 0.
- With PARSER_ARB_PKT_CNT_EN: 5 packets on port 0 and 2 on port 3 -> pkt_cnt slice 0=5, slice 3=2, others 0.
